// File: rtl/jt49_mavg_pkg.sv
// Shared constants and types for the jt49 moving-average stage.
// Optional feature macro: JT49_MAVG_ROUND_EN (round-half-up output).
package jt49_mavg_pkg;

  localparam int DEF_DW    = 8;
  localparam int DEF_LOG2N = 3;
  localparam int N         = 1 << DEF_LOG2N;
  localparam int SW        = DEF_DW + DEF_LOG2N;

  typedef logic signed [DEF_DW-1:0] sample_t;
  typedef logic signed [SW-1:0]     sum_t;

  // Window length for a given log2 size
  function automatic int win_size(input int log2n);
    return 1 << log2n;
  endfunction

endpackage

// File: rtl/jt49_mavg_dly.sv
// Circular delay line of 2^LOG2N samples for the jt49 moving average.
// Presents the entry about to be overwritten on 'old'.
module jt49_mavg_dly
  import jt49_mavg_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int LOG2N = DEF_LOG2N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen,
  input  logic signed [DW-1:0] din,
  output logic signed [DW-1:0] old
);

  localparam int unsigned LEN = win_size(LOG2N);

  logic signed [DW-1:0] line [LEN];
  logic [LOG2N-1:0]     ptr;

  assign old = line[ptr];

  // Write the new sample over the oldest one and advance the pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LEN; i++) line[i] <= '0;
      ptr <= '0;
    end else if (cen) begin
      line[ptr] <= din;
      ptr       <= ptr + LOG2N'(1);
    end
  end

endmodule

// File: rtl/jt49_mavg.sv
// Boxcar low-pass stage after the jt49 DC-removal filter.
// Running sum over a 2^LOG2N window, one add/subtract per sample.
// Optional feature macro: JT49_MAVG_ROUND_EN (round-half-up instead of floor).
module jt49_mavg
  import jt49_mavg_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int LOG2N = DEF_LOG2N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen,
  input  logic signed [DW-1:0] din,
  output logic signed [DW-1:0] dout,
  output logic                 settled
);

  localparam int WS = DW + LOG2N;
  localparam int FW = LOG2N + 1;
  localparam int WN = win_size(LOG2N);

  if (LOG2N < 1 || LOG2N > 6) begin : g_bad_log2n
    $error("jt49_mavg: LOG2N must be in 1..6");
  end

  logic signed [DW-1:0] old;
  logic signed [WS-1:0] sum, sum_next, din_x, old_x;
  logic signed [DW-1:0] q;
  logic [FW-1:0]        fill, fill_next;

  jt49_mavg_dly #(
    .DW    (DW),
    .LOG2N (LOG2N)
  ) u_dly (
    .clk (clk),
    .rst (rst),
    .cen (cen),
    .din (din),
    .old (old)
  );

  assign din_x     = WS'(din);
  assign old_x     = WS'(old);
  assign sum_next  = sum + din_x - old_x;
  assign fill_next = (fill == FW'(WN)) ? fill : fill + FW'(1);

`ifdef JT49_MAVG_ROUND_EN
  localparam int RW = WS + 1;
  localparam logic signed [RW-1:0] HALF = RW'(1) << (LOG2N - 1);
  logic signed [RW-1:0] rnd;

  // Round half up: bias by half an LSB of the output before the shift
  always_comb begin
    rnd = RW'(sum_next) + HALF;
    q   = DW'(rnd >>> LOG2N);
  end
`else
  // Floor division by the window length
  always_comb begin
    q = DW'(sum_next >>> LOG2N);
  end
`endif

  // Running sum, warm-up counter and registered output
  always_ff @(posedge clk) begin
    if (rst) begin
      sum     <= '0;
      fill    <= '0;
      dout    <= '0;
      settled <= 1'b0;
    end else if (cen) begin
      sum     <= sum_next;
      fill    <= fill_next;
      dout    <= q;
      settled <= (fill_next == FW'(WN));
    end
  end

endmodule

// File: tb/tb_jt49_mavg.sv
// Directed self-checking bench for jt49_mavg (LOG2N=3, DW=8).
module tb_jt49_mavg;
  import jt49_mavg_pkg::*;

  logic    clk = 1'b0;
  logic    rst = 1'b0;
  logic    cen = 1'b0;
  sample_t din = '0;
  sample_t dout;
  logic    settled;

  int tests = 0;
  int fails = 0;

  jt49_mavg #(
    .DW    (8),
    .LOG2N (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .din     (din),
    .dout    (dout),
    .settled (settled)
  );

  always #5 clk = ~clk;

  // one clock with the given inputs; outputs sampled 1 time unit after the edge
  task automatic tick(input logic r, input logic c, input int d);
    rst = r;
    cen = c;
    din = sample_t'(d);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cen = 1'b0;
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 0);
    tick(1'b1, 1'b0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (dout !== 8'sd0 || settled !== 1'b0) begin
      fails++;
      $display("FAIL reset: dout=%0d settled=%0b required dout=0 settled=0", dout, settled);
    end
  endtask

  task automatic test_step();
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      tick(1'b0, 1'b1, 64);
      tests++;
      if (dout !== sample_t'((k > 8 ? 8 : k) * 8) || settled !== (k >= 8)) begin
        fails++;
        $display("FAIL step[%0d]: dout=%0d settled=%0b required dout=%0d settled=%0b",
                 k, dout, settled, (k > 8 ? 8 : k) * 8, (k >= 8));
      end
      for (int j = 0; j < 3; j++) begin
        tick(1'b0, 1'b0, 0);
        tests++;
        if (dout !== sample_t'((k > 8 ? 8 : k) * 8)) begin
          fails++;
          $display("FAIL step_hold[%0d]: dout=%0d required %0d", k, dout, (k > 8 ? 8 : k) * 8);
        end
      end
    end
  endtask

  // follows test_step: window full of 64, sum 512
  task automatic test_cen_gating();
    for (int j = 0; j < 20; j++) begin
      tick(1'b0, 1'b0, (j * 37) - 100);
      tests++;
      if (dout !== 8'sd64 || settled !== 1'b1) begin
        fails++;
        $display("FAIL cen_gate[%0d]: dout=%0d settled=%0b required dout=64 settled=1", j, dout, settled);
      end
    end
    // one zero sample: (512 - 64 + 0) / 8 = 56
    tick(1'b0, 1'b1, 0);
    tests++;
    if (dout !== 8'sd56) begin
      fails++;
      $display("FAIL cen_gate_next: dout=%0d required 56", dout);
    end
  endtask

  task automatic test_neg_full();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0, 1'b1, -128);
      tests++;
      if (dout !== sample_t'(-16 * k)) begin
        fails++;
        $display("FAIL neg_full[%0d]: dout=%0d required %0d", k, dout, -16 * k);
      end
    end
    tests++;
    if (settled !== 1'b1) begin
      fails++;
      $display("FAIL neg_settled: settled=%0b required 1", settled);
    end
  endtask

  task automatic test_alternating();
    int exp_v;
`ifdef JT49_MAVG_ROUND_EN
    exp_v = 0;
`else
    exp_v = -1;
`endif
    do_reset();
    for (int k = 0; k < 16; k++) begin
      tick(1'b0, 1'b1, (k % 2 == 0) ? 127 : -128);
      if (k >= 7) begin
        tests++;
        if (dout !== sample_t'(exp_v)) begin
          fails++;
          $display("FAIL alternating[%0d]: dout=%0d required %0d", k, dout, exp_v);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 100);
    tick(1'b1, 1'b1, 100);
    tests++;
    if (dout !== 8'sd0 || settled !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: dout=%0d settled=%0b required dout=0 settled=0", dout, settled);
    end
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0, 1'b1, -40);
      tests++;
      if (dout !== sample_t'(-5 * k) || settled !== (k == 8)) begin
        fails++;
        $display("FAIL mid_reset_run[%0d]: dout=%0d settled=%0b required dout=%0d settled=%0b",
                 k, dout, settled, -5 * k, (k == 8));
      end
    end
  endtask

  task automatic test_wrap();
    int exp_v;
    do_reset();
    for (int v = 0; v < 32; v++) begin
      tick(1'b0, 1'b1, v);
      if (v >= 7) begin
`ifdef JT49_MAVG_ROUND_EN
        exp_v = v - 3;
`else
        exp_v = v - 4;
`endif
        tests++;
        if (dout !== sample_t'(exp_v)) begin
          fails++;
          $display("FAIL wrap[%0d]: dout=%0d required %0d", v, dout, exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_cen_gating();
    test_neg_full();
    test_alternating();
    test_mid_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
